// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the fetch/data memory port arbiter.
// Holds FSM encodings, access-width codes, requester ids and counter sizing.
package mem_port_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  // A disabled timeout (0) still needs a legal one-bit counter.
  function automatic int tmo_cnt_width(input int timeout);
    if (timeout < 1) return 1;
    return $clog2(timeout + 1);
  endfunction

  function automatic logic data_misaligned(input logic [1:0] width,
                                           input logic [1:0] addr_lo);
    logic bad;
    case (width)
      WIDTH_BYTE: bad = 1'b0;
      WIDTH_HALF: bad = addr_lo[0];
      WIDTH_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles a bus transaction has been outstanding; expired is a registered
// compare, valid in the cycle the count reaches TIMEOUT-1. TIMEOUT=0 never expires.
module bus_timeout_counter
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW     = tmo_cnt_width(TIMEOUT);
  localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LAST_I);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (TIMEOUT > 0) && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store.
// Req->ack is 2 cycles with zero-wait memory; malformed or timed-out accesses ack with err.
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT    = 255,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_width,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        grant_data
);

  localparam logic LAST_GRANT_RST = DATA_FIRST ? REQ_FETCH : REQ_DATA;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_data_q, grant_data_d;
  logic        req_we_q, req_we_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [1:0]  req_width_q, req_width_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic pick_data;
  logic bad_access;
  logic tmo_expired;
  logic busy;
  logic resp;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_data_d = grant_data_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_width_d  = req_width_q;
    req_wdata_d  = req_wdata_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    pick_data    = 1'b0;
    bad_access   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
          // Under conflict, the requester that did not win last time goes next.
          pick_data    = d_req && (!f_req || (last_grant_q == REQ_FETCH));
          grant_data_d = pick_data;
          last_grant_d = pick_data;
          if (pick_data) begin
            bad_access  = data_misaligned(d_width, d_addr[1:0]);
            req_we_d    = d_we;
            req_addr_d  = d_addr;
            req_width_d = d_width;
            req_wdata_d = d_we ? d_wdata : '0;
          end else begin
            bad_access  = (f_addr[1:0] != 2'b00);
            req_we_d    = 1'b0;
            req_addr_d  = f_addr;
            req_width_d = WIDTH_WORD;
            req_wdata_d = '0;
          end
          if (bad_access) begin
            state_d      = S_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          state_d      = S_RESP;
          resp_err_d   = 1'b0;
          resp_rdata_d = req_we_q ? '0 : mem_rdata;
        end else if (tmo_expired) begin
          state_d      = S_RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= LAST_GRANT_RST;
      grant_data_q <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_width_q  <= '0;
      req_wdata_q  <= '0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_data_q <= grant_data_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_width_q  <= req_width_d;
      req_wdata_q  <= req_wdata_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (busy),
    .clr     (state_d != S_BUSY),
    .expired (tmo_expired)
  );

  assign busy = (state_q == S_BUSY);
  assign resp = (state_q == S_RESP);

  // Memory side is driven only while BUSY so stale fields never leak.
  assign mem_req   = busy;
  assign mem_we    = busy && req_we_q;
  assign mem_addr  = busy ? req_addr_q  : '0;
  assign mem_width = busy ? req_width_q : '0;
  assign mem_wdata = busy ? req_wdata_q : '0;

  assign f_ack   = resp && !grant_data_q;
  assign f_err   = f_ack && resp_err_q;
  assign f_rdata = f_ack ? resp_rdata_q : '0;
  assign d_ack   = resp && grant_data_q;
  assign d_err   = d_ack && resp_err_q;
  assign d_rdata = d_ack ? resp_rdata_q : '0;

  assign grant_data = grant_data_q;

endmodule
